// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with valid/ready request and response ports and an RD_LAT-deep read pipeline.
// Optional macro DMEM_ALIGN_CHECK_EN: misaligned half-word/word accesses become faults instead of being truncated.
module data_mem_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             err;
    logic             load;
    logic [1:0]       size;
    logic             sgn;
    logic [OFF_W-1:0] off;
  } meta_t;

  meta_t             meta_q [RD_LAT];
  logic [DATA_W-1:0] raw_q  [RD_LAT];
  // Contents are never reset; only the pipeline state is.
  logic [DATA_W-1:0] mem    [DEPTH];

  logic [OFF_W-1:0]  off;
  logic [OFF_W-1:0]  eff_off;
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              fault;
  logic              advance;
  logic              accept;
  logic              do_write;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] wdata_rep;
  meta_t             meta_in;

  assign off      = req_addr[OFF_W-1:0];
  assign idx      = req_addr[OFF_W +: IDX_W];
  assign in_range = (req_addr >> OFF_W) < ADDR_W'(DEPTH);

  always_comb begin
    case (req_size)
      2'b00:   eff_off = off;
      2'b01:   eff_off = {off[OFF_W-1:1], 1'b0};
      default: eff_off = '0;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && off[0]) ||
                      ((req_size == 2'b10) && (off != '0));
  assign fault = !in_range || (req_size == 2'b11) || misaligned;
`else
  assign fault = !in_range || (req_size == 2'b11);
`endif

  assign advance   = !(rsp_valid && !rsp_ready);
  assign req_ready = advance && rst_n;
  assign accept    = req_valid && req_ready;
  assign do_write  = accept && req_we && !fault;

  // Sub-word store data is replicated across the word so each lane just picks its own byte.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign be[gi] = (req_size == 2'b10) ||
                    ((req_size == 2'b00) && (eff_off == OFF_W'(gi))) ||
                    ((req_size == 2'b01) && (eff_off[OFF_W-1:1] == (OFF_W-1)'(gi / 2)));
    assign wdata_rep[gi*8 +: 8] = (req_size == 2'b00) ? req_wdata[7:0] :
                                  (req_size == 2'b01) ? req_wdata[(gi % 2)*8 +: 8] :
                                                        req_wdata[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
      end
    end
    if (accept) raw_q[0] <= mem[idx];
    if (advance) begin
      for (int k = 1; k < RD_LAT; k++) raw_q[k] <= raw_q[k-1];
    end
  end

  assign meta_in = '{valid: accept, err: fault, load: !req_we, size: req_size,
                     sgn: req_signed, off: eff_off};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) meta_q[k] <= '0;
    end else if (advance) begin
      meta_q[0] <= meta_in;
      for (int k = 1; k < RD_LAT; k++) meta_q[k] <= meta_q[k-1];
    end
  end

  // Lane extraction and extension happen on the held raw word, so a stalled response stays stable.
  meta_t             last;
  logic [DATA_W-1:0] last_raw;
  logic [DATA_W-1:0] ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  assign last     = meta_q[RD_LAT-1];
  assign last_raw = raw_q[RD_LAT-1];

  always_comb begin
    ld_byte = last_raw[{last.off, 3'b000} +: 8];
    ld_half = last_raw[{last.off[OFF_W-1:1], 4'b0000} +: 16];
    case (last.size)
      2'b00:   ext = {{(DATA_W-8){last.sgn & ld_byte[7]}}, ld_byte};
      2'b01:   ext = {{(DATA_W-16){last.sgn & ld_half[15]}}, ld_half};
      default: ext = last_raw;
    endcase
  end

  assign rsp_valid = last.valid;
  assign rsp_err   = last.valid && last.err;
  assign rsp_rdata = (last.valid && last.load && !last.err) ? ext : '0;
endmodule
